// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Brief    : Shared types and constants for the divider dispatcher.
//  Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

   localparam int DIV_W    = 32;
   localparam int DIV_TAGW = 4;

   // Dispatcher sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DZ    = 2'd3
   } state_e;

   // One queued divide request
   typedef struct packed {
      logic [DIV_W-1:0]    num;
      logic [DIV_W-1:0]    den;
      logic [DIV_TAGW-1:0] tag;
   } req_t;

   // Quotient reported for divide-by-zero and for a watchdog abort
   localparam logic [DIV_W-1:0] DZ_QUOT = '1;

endpackage
`default_nettype wire

// File: rtl/div_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_dispatcher_if
//  Brief    : Request stream, divider bus and result stream of the dispatcher.
//  Revision : 1.0 - initial release
// ============================================================================
interface div_dispatcher_if
   import div_pkg::*;
#(
   parameter int tamanyo = DIV_W,
   parameter int TAGW    = DIV_TAGW
);

   logic               in_valid;
   logic               in_ready;
   logic [tamanyo-1:0] in_num;
   logic [tamanyo-1:0] in_den;
   logic [TAGW-1:0]    in_tag;

   logic               div_start;
   logic [tamanyo-1:0] div_num;
   logic [tamanyo-1:0] div_den;
   logic [tamanyo-1:0] div_coc;
   logic [tamanyo-1:0] div_res;
   logic               div_done;

   logic               out_valid;
   logic               out_ready;
   logic [tamanyo-1:0] out_coc;
   logic [tamanyo-1:0] out_res;
   logic [TAGW-1:0]    out_tag;
   logic               out_dz;

   // Dispatcher side
   modport slave (
      input  in_valid, in_num, in_den, in_tag,
      output in_ready,
      output div_start, div_num, div_den,
      input  div_coc, div_res, div_done,
      output out_valid, out_coc, out_res, out_tag, out_dz,
      input  out_ready
   );

   // Environment side: request producer, divider and result consumer
   modport master (
      output in_valid, in_num, in_den, in_tag,
      input  in_ready,
      input  div_start, div_num, div_den,
      output div_coc, div_res, div_done,
      input  out_valid, out_coc, out_res, out_tag, out_dz,
      output out_ready
   );

endinterface
`default_nettype wire

// File: rtl/div_op_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : div_op_fifo
//  Brief    : Synchronous FIFO of divide requests with an occupancy count.
//             Pushes into a full FIFO and pops from an empty one are dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module div_op_fifo
   import div_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wire logic                   CLK,
   input  wire logic                   RSTa,
   input  wire logic                   push_i,
   input  wire req_t                   wdata_i,
   input  wire logic                   pop_i,
   output req_t                        rdata_o,
   output logic [$clog2(DEPTH):0]      count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   req_t            mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW:0]     cnt_q;
   logic            push_ok;
   logic            pop_ok;

   assign push_ok = push_i && (cnt_q != FULL_CNT);
   assign pop_ok  = pop_i  && (cnt_q != '0);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = cnt_q;

   // Storage array; contents need no reset since count gates every read
   always_ff @(posedge CLK) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge CLK) begin
      if (!RSTa) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/div_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : div_dispatcher
//  Brief    : Queues divide requests, feeds them one at a time to the
//             sequential divider, and returns results in request order.
//             Divide-by-zero is answered locally; a watchdog aborts a
//             divider that never reports Done.
//  Revision : 1.0 - initial release
// ============================================================================
module div_dispatcher
   import div_pkg::*;
#(
   parameter int tamanyo = DIV_W,
   parameter int DEPTH   = 4,
   parameter int TAGW    = DIV_TAGW,
   parameter int TMO     = 2*tamanyo+8
) (
   input  wire logic         CLK,
   input  wire logic         RSTa,
   div_dispatcher_if.slave   bus,
   output logic              busy,
   output logic              tmo_err
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam int WW = $clog2(TMO + 1);
   localparam logic [WW-1:0] WDG_LAST = WW'(TMO - 1);

   state_e              state_q;
   logic                div_start_q;
   logic [tamanyo-1:0]  div_num_q;
   logic [tamanyo-1:0]  div_den_q;
   logic [TAGW-1:0]     op_tag_q;
   logic                out_valid_q;
   logic [tamanyo-1:0]  out_coc_q;
   logic [tamanyo-1:0]  out_res_q;
   logic [TAGW-1:0]     out_tag_q;
   logic                out_dz_q;
   logic                tmo_err_q;
   logic [WW-1:0]       wdg_q;

   req_t                push_req;
   req_t                head;
   logic [CW-1:0]       fifo_cnt;
   logic                fifo_full;
   logic                fifo_empty;
   logic                push_d;
   logic                slot_free_d;
   logic                pop_d;

   assign fifo_full   = (fifo_cnt == FULL_CNT);
   assign fifo_empty  = (fifo_cnt == '0);
   assign push_d      = bus.in_valid && !fifo_full;
   // The result slot is usable if empty or being drained on this edge
   assign slot_free_d = !out_valid_q || bus.out_ready;
   assign pop_d       = (state_q == IDLE) && !fifo_empty && slot_free_d;
   assign push_req    = '{num: bus.in_num, den: bus.in_den, tag: bus.in_tag};

   div_op_fifo #(
      .DEPTH   (DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RSTa    (RSTa),
      .push_i  (push_d),
      .wdata_i (push_req),
      .pop_i   (pop_d),
      .rdata_o (head),
      .count_o (fifo_cnt)
   );

   // Issue/collect sequencer with all outputs registered
   always_ff @(posedge CLK) begin
      if (!RSTa) begin
         state_q     <= IDLE;
         div_start_q <= 1'b0;
         div_num_q   <= '0;
         div_den_q   <= '0;
         op_tag_q    <= '0;
         out_valid_q <= 1'b0;
         out_coc_q   <= '0;
         out_res_q   <= '0;
         out_tag_q   <= '0;
         out_dz_q    <= 1'b0;
         tmo_err_q   <= 1'b0;
         wdg_q       <= '0;
      end else begin
         div_start_q <= 1'b0;
         if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop_d) begin
                  div_num_q <= head.num;
                  div_den_q <= head.den;
                  op_tag_q  <= head.tag;
                  if (head.den == '0) begin
                     state_q <= DZ;
                  end else begin
                     state_q     <= ISSUE;
                     div_start_q <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               state_q <= WAIT;
               wdg_q   <= '0;
            end
            WAIT: begin
               if (bus.div_done) begin
                  out_coc_q   <= bus.div_coc;
                  out_res_q   <= bus.div_res;
                  out_tag_q   <= op_tag_q;
                  out_dz_q    <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= IDLE;
               end else if (wdg_q == WDG_LAST) begin
                  // Divider presumed hung: flag it and release the slot
                  tmo_err_q   <= 1'b1;
                  out_coc_q   <= DZ_QUOT;
                  out_res_q   <= div_num_q;
                  out_tag_q   <= op_tag_q;
                  out_dz_q    <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  wdg_q <= wdg_q + 1'b1;
               end
            end
            DZ: begin
               out_coc_q   <= DZ_QUOT;
               out_res_q   <= div_num_q;
               out_tag_q   <= op_tag_q;
               out_dz_q    <= 1'b1;
               out_valid_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = !fifo_full;
   assign bus.div_start = div_start_q;
   assign bus.div_num   = div_num_q;
   assign bus.div_den   = div_den_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_coc   = out_coc_q;
   assign bus.out_res   = out_res_q;
   assign bus.out_tag   = out_tag_q;
   assign bus.out_dz    = out_dz_q;
   assign busy          = (state_q != IDLE) || !fifo_empty;
   assign tmo_err       = tmo_err_q;

endmodule
`default_nettype wire

// File: tb/tb_div_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_dispatcher
//  Brief    : Self-checking bench for div_dispatcher with a behavioural
//             divider and a queue-based reference of expected results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_dispatcher;

   localparam int W   = 32;
   localparam int TW  = 4;
   localparam int TMO = 2*W+8;

   typedef struct packed {
      logic [W-1:0]  coc;
      logic [W-1:0]  res;
      logic [TW-1:0] tag;
      logic          dz;
   } rsp_t;

   logic CLK  = 1'b0;
   logic RSTa = 1'b0;
   logic busy;
   logic tmo_err;

   int   n_cmp = 0;
   int   n_err = 0;
   int   acc_cnt = 0;
   int   start_cnt = 0;
   bit   hang = 1'b0;
   bit   stray_req = 1'b0;
   int   lat_fix = 0;
   rsp_t exp_q[$];
   rsp_t got_q[$];

   logic [W-1:0] m_q;
   logic [W-1:0] m_r;
   int           d_cnt;

   always #5 CLK = ~CLK;

   div_dispatcher_if #(.tamanyo(W), .TAGW(TW)) bus ();

   div_dispatcher #(
      .tamanyo (W),
      .DEPTH   (4),
      .TAGW    (TW),
      .TMO     (TMO)
   ) dut (
      .CLK     (CLK),
      .RSTa    (RSTa),
      .bus     (bus),
      .busy    (busy),
      .tmo_err (tmo_err)
   );

   // Reference result of a request: truncating signed division, or DZ answer
   function automatic rsp_t model(input logic [W-1:0] n, input logic [W-1:0] d,
                                  input logic [TW-1:0] t);
      rsp_t r;
      r.tag = t;
      if (d == '0) begin
         r.coc = '1;
         r.res = n;
         r.dz  = 1'b1;
      end else begin
         r.coc = W'($signed(n) / $signed(d));
         r.res = W'($signed(n) % $signed(d));
         r.dz  = 1'b0;
      end
      return r;
   endfunction

   // Behavioural sequential divider: random latency, optional hang, stray Done
   always @(posedge CLK) begin
      if (!RSTa) begin
         d_cnt        <= 0;
         bus.div_done <= 1'b0;
         bus.div_coc  <= '0;
         bus.div_res  <= '0;
      end else begin
         bus.div_done <= stray_req;
         if (d_cnt == 1) begin
            bus.div_done <= 1'b1;
            bus.div_coc  <= m_q;
            bus.div_res  <= m_r;
         end
         if (d_cnt > 0) d_cnt <= d_cnt - 1;
         if (bus.div_start) begin
            m_q   <= W'($signed(bus.div_num) / $signed(bus.div_den));
            m_r   <= W'($signed(bus.div_num) % $signed(bus.div_den));
            d_cnt <= hang ? 0 : ((lat_fix > 0) ? lat_fix : int'($urandom_range(8, 1)));
         end
      end
   end

   // Observe accepted requests and delivered results between clock edges
   always @(negedge CLK) begin
      if (!RSTa) begin
         exp_q.delete();
         got_q.delete();
      end else begin
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.in_num, bus.in_den, bus.in_tag));
            acc_cnt++;
         end
         if (bus.out_valid && bus.out_ready)
            got_q.push_back({bus.out_coc, bus.out_res, bus.out_tag, bus.out_dz});
         if (bus.div_start) start_cnt++;
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [W-1:0] n, input logic [W-1:0] d, input logic [TW-1:0] t);
      bit fire;
      int g;
      g = 0;
      bus.in_num   = n;
      bus.in_den   = d;
      bus.in_tag   = t;
      bus.in_valid = 1'b1;
      do begin
         fire = bus.in_ready;
         step();
         g++;
      end while (!fire && g < 300);
      bus.in_valid = 1'b0;
      if (!fire) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_accept tag %0d got not-accepted required accepted", t);
      end
   endtask

   task automatic wait_got(input int n);
      for (int i = 0; i < 600 && got_q.size() < n; i++) @(posedge CLK);
      #1;
   endtask

   function automatic logic [W-1:0] rnd_den();
      int v;
      v = int'($urandom_range(100, 1));
      if ($urandom_range(1, 0) == 1) v = -v;
      return W'(v);
   endfunction

   task automatic test_reset();
      RSTa = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_num = '0;
      bus.in_den = '0;
      bus.in_tag = '0;
      bus.out_ready = 1'b1;
      repeat (3) step();
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b required 1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b required 0", bus.out_valid); end
      n_cmp++; if (bus.div_start !== 1'b0) begin n_err++; $display("FAIL reset_div_start got %b required 0", bus.div_start); end
      n_cmp++; if (bus.out_dz !== 1'b0) begin n_err++; $display("FAIL reset_out_dz got %b required 0", bus.out_dz); end
      n_cmp++; if (tmo_err !== 1'b0) begin n_err++; $display("FAIL reset_tmo_err got %b required 0", tmo_err); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b required 0", busy); end
      n_cmp++;
      if ({bus.out_coc, bus.out_res, bus.out_tag, bus.div_num, bus.div_den} !== '0) begin
         n_err++;
         $display("FAIL reset_data got coc=%h res=%h tag=%h num=%h den=%h required all 0",
                  bus.out_coc, bus.out_res, bus.out_tag, bus.div_num, bus.div_den);
      end
      RSTa = 1'b1;
      step();
   endtask

   task automatic test_basic_div();
      int   s0;
      rsp_t r;
      bus.out_ready = 1'b1;
      s0 = start_cnt;
      send(32'd100, 32'd7, 4'd3);
      n_cmp++; if (bus.div_start !== 1'b0) begin n_err++; $display("FAIL start_edge0 got %b required 0", bus.div_start); end
      step();
      n_cmp++; if (bus.div_start !== 1'b1) begin n_err++; $display("FAIL start_edge1 got %b required 1", bus.div_start); end
      n_cmp++; if ({bus.div_num, bus.div_den} !== {32'd100, 32'd7}) begin n_err++; $display("FAIL div_operands got %h/%h required 100/7", bus.div_num, bus.div_den); end
      step();
      n_cmp++; if (bus.div_start !== 1'b0) begin n_err++; $display("FAIL start_edge2 got %b required 0", bus.div_start); end
      wait_got(1);
      n_cmp++;
      if (got_q.size() < 1) begin
         n_err++; $display("FAIL basic_result got none required 1 result");
      end else begin
         r = got_q.pop_front();
         if (r !== {32'd14, 32'd2, 4'd3, 1'b0}) begin n_err++; $display("FAIL basic_100_7 got %h required coc=e res=2 tag=3 dz=0", r); end
      end
      n_cmp++; if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL start_pulse_len got %0d cycles required 1", start_cnt - s0); end
      send(32'hFFFF_FF9C, 32'd7, 4'd5);
      send(32'd100, 32'hFFFF_FFF9, 4'd6);
      wait_got(2);
      n_cmp++;
      if (got_q.size() < 2) begin
         n_err++; $display("FAIL signed_results got %0d required 2", got_q.size());
      end else begin
         if (got_q[0] !== {32'hFFFF_FFF2, 32'hFFFF_FFFE, 4'd5, 1'b0}) begin n_err++; $display("FAIL neg_num got %h required coc=fffffff2 res=fffffffe tag=5", got_q[0]); end
         n_cmp++;
         if (got_q[1] !== {32'hFFFF_FFF2, 32'd2, 4'd6, 1'b0}) begin n_err++; $display("FAIL neg_den got %h required coc=fffffff2 res=2 tag=6", got_q[1]); end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_div_zero();
      int s0;
      bus.out_ready = 1'b1;
      s0 = start_cnt;
      send(32'd55, 32'd0, 4'd9);
      step();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL dz_edge1_valid got %b required 0", bus.out_valid); end
      step();
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL dz_edge2_valid got %b required 1", bus.out_valid); end
      n_cmp++;
      if ({bus.out_coc, bus.out_res, bus.out_tag, bus.out_dz} !== {32'hFFFF_FFFF, 32'd55, 4'd9, 1'b1}) begin
         n_err++;
         $display("FAIL dz_fields got coc=%h res=%h tag=%h dz=%b required ffffffff/37/9/1",
                  bus.out_coc, bus.out_res, bus.out_tag, bus.out_dz);
      end
      step();
      n_cmp++; if (start_cnt !== s0) begin n_err++; $display("FAIL dz_no_start got %0d starts required 0", start_cnt - s0); end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int           a0;
      logic [W-1:0] n6, d6;
      bus.out_ready = 1'b0;
      a0 = acc_cnt;
      for (int t = 1; t <= 5; t++) send($urandom, rnd_den(), TW'(t));
      n6 = $urandom;
      d6 = rnd_den();
      bus.in_num = n6;
      bus.in_den = d6;
      bus.in_tag = 4'd6;
      bus.in_valid = 1'b1;
      repeat (20) step();
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b required 0", bus.in_ready); end
      n_cmp++; if (acc_cnt - a0 !== 5) begin n_err++; $display("FAIL full_accepts got %0d required 5", acc_cnt - a0); end
      n_cmp++;
      if ({bus.out_valid, bus.out_tag} !== {1'b1, 4'd1}) begin
         n_err++; $display("FAIL held_result got valid=%b tag=%0d required valid=1 tag=1", bus.out_valid, bus.out_tag);
      end
      bus.out_ready = 1'b1;
      send(n6, d6, 4'd6);
      send($urandom, rnd_den(), 4'd7);
      wait_got(7);
      n_cmp++;
      if (got_q.size() != 7 || exp_q.size() != 7) begin
         n_err++; $display("FAIL b2b_count got %0d required 7", got_q.size());
      end else begin
         for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i] || got_q[i].tag !== TW'(i + 1)) begin
               n_err++; $display("FAIL b2b_result[%0d] got %h required %h", i, got_q[i], exp_q[i]);
            end
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_random();
      localparam int N = 40;
      fork
         begin
            for (int i = 0; i < N; i++) begin
               logic [W-1:0] n, d;
               repeat ($urandom_range(2, 0)) step();
               n = ($urandom_range(1, 0) == 1) ? W'($urandom) : W'($urandom_range(5000, 0));
               d = ($urandom_range(7, 0) == 0) ? '0 : rnd_den();
               if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) d = 32'd1;
               send(n, d, TW'($urandom));
            end
         end
         begin
            for (int c = 0; c < 4000 && got_q.size() < N; c++) begin
               bus.out_ready = ($urandom_range(2, 0) != 0);
               step();
            end
            bus.out_ready = 1'b1;
         end
      join
      n_cmp++;
      if (got_q.size() != N || exp_q.size() != N) begin
         n_err++; $display("FAIL rand_count got %0d required %0d", got_q.size(), N);
      end else begin
         for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
               n_err++; $display("FAIL rand_result[%0d] got %h required %h", i, got_q[i], exp_q[i]);
            end
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int   s0;
      int   g;
      rsp_t r;
      bus.out_ready = 1'b1;
      lat_fix = 30;
      s0 = start_cnt;
      send(32'd1000, 32'd3, 4'hA);
      send(32'd5, 32'd2, 4'hB);
      send(32'd7, 32'd3, 4'hC);
      g = 0;
      while (start_cnt == s0 && g < 50) begin step(); g++; end
      repeat (3) step();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL pre_reset_busy got %b required 1", busy); end
      RSTa = 1'b0;
      step();
      RSTa = 1'b1;
      lat_fix = 0;
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, busy} !== 3'b010) begin
         n_err++; $display("FAIL midreset_state got valid=%b ready=%b busy=%b required 0/1/0", bus.out_valid, bus.in_ready, busy);
      end
      stray_req = 1'b1;
      step();
      stray_req = 1'b0;
      repeat (4) step();
      n_cmp++;
      if ({bus.out_valid, busy} !== 2'b00 || got_q.size() != 0) begin
         n_err++; $display("FAIL stray_done got valid=%b busy=%b results=%0d required 0/0/0", bus.out_valid, busy, got_q.size());
      end
      send(32'd9, 32'd4, 4'h2);
      wait_got(1);
      n_cmp++;
      if (got_q.size() < 1) begin
         n_err++; $display("FAIL post_reset_result got none required 1 result");
      end else begin
         r = got_q.pop_front();
         if (r !== {32'd2, 32'd1, 4'h2, 1'b0}) begin n_err++; $display("FAIL post_reset_9_4 got %h required coc=2 res=1 tag=2", r); end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_timeout();
      int n;
      bus.out_ready = 1'b1;
      n_cmp++; if (tmo_err !== 1'b0) begin n_err++; $display("FAIL tmo_err_before got %b required 0", tmo_err); end
      hang = 1'b1;
      send(32'd77, 32'd5, 4'h7);
      send(32'd40, 32'd6, 4'h8);
      n = 0;
      while (!bus.div_start && n < 10) begin step(); n++; end
      n = 0;
      while (!bus.out_valid && n < TMO + 40) begin step(); n++; end
      hang = 1'b0;
      n_cmp++; if (n !== TMO + 1) begin n_err++; $display("FAIL tmo_latency got %0d edges required %0d", n, TMO + 1); end
      n_cmp++; if (tmo_err !== 1'b1) begin n_err++; $display("FAIL tmo_err_set got %b required 1", tmo_err); end
      n_cmp++;
      if ({bus.out_coc, bus.out_res, bus.out_tag, bus.out_dz} !== {32'hFFFF_FFFF, 32'd77, 4'h7, 1'b0}) begin
         n_err++;
         $display("FAIL tmo_fields got coc=%h res=%h tag=%h dz=%b required ffffffff/4d/7/0",
                  bus.out_coc, bus.out_res, bus.out_tag, bus.out_dz);
      end
      wait_got(2);
      n_cmp++;
      if (got_q.size() < 2) begin
         n_err++; $display("FAIL tmo_next got %0d results required 2", got_q.size());
      end else if (got_q[1] !== {32'd6, 32'd4, 4'h8, 1'b0}) begin
         n_err++; $display("FAIL tmo_next_40_6 got %h required coc=6 res=4 tag=8", got_q[1]);
      end
      n_cmp++; if (tmo_err !== 1'b1) begin n_err++; $display("FAIL tmo_err_sticky got %b required 1", tmo_err); end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic_div();
      test_div_zero();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got still-running required finished");
      $fatal(1, "simulation time limit");
   end

endmodule
`default_nettype wire
